// File: rtl/proc_pkg.sv
// proc_pkg: definitions shared by the processor-side blocks.
//   - opcode constants for the instruction set
//   - instruction field positions (opcode, rA, rB, imm)
//   - the program-loader state enum
//   - opcode_of(): extracts the opcode field from an instruction word
package proc_pkg;

  // Instruction opcodes (bits [31:24]).
  localparam logic [7:0] OP_IRMOV = 8'h10;
  localparam logic [7:0] OP_ADD   = 8'h20;
  localparam logic [7:0] OP_SUB   = 8'h21;
  localparam logic [7:0] OP_AND   = 8'h32;

  // Instruction field positions.
  localparam int OPC_HI = 31;
  localparam int OPC_LO = 24;
  localparam int RA_HI  = 23;
  localparam int RA_LO  = 20;
  localparam int RB_HI  = 19;
  localparam int RB_LO  = 16;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  // Loader states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_RUN   = 2'd2,
    ST_ERROR = 2'd3
  } ldr_state_e;

  function automatic logic [7:0] opcode_of(input logic [31:0] word);
    return word[OPC_HI:OPC_LO];
  endfunction

endpackage

// File: rtl/opcode_check.sv
// opcode_check: combinational legality decode of an instruction opcode.
// Ports:
//   opcode  in  8  opcode field of the incoming instruction word
//   legal   out 1  opcode belongs to the supported instruction set
module opcode_check
  import proc_pkg::*;
(
  input  logic [7:0] opcode,
  output logic       legal
);

  always_comb begin
    legal = 1'b0;
    unique case (opcode)
      OP_IRMOV,
      OP_ADD,
      OP_SUB,
      OP_AND:  legal = 1'b1;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: program loader in front of the instruction-memory write port.
// Accepts instruction words over a valid/ready stream, writes them to
// consecutive addresses starting at 0 while the processor is held idle, then
// raises working once the final word has been written.
//
// Optional feature: define IMEM_LOADER_OPCODE_CHECK_EN to reject words whose
// opcode is not in the supported set (block goes to ERROR, word not written).
//
// Ports:
//   clock     in  1         system clock
//   reset_n   in  1         asynchronous active-low reset
//   start     in  1         begin a load (honoured in IDLE / ERROR)
//   halt      in  1         stop execution (honoured in RUN)
//   in_valid  in  1         in_data holds a word
//   in_data   in  DATA_W    instruction word
//   in_last   in  1         final word of the program
//   in_ready  out 1         loader accepts a word this cycle
//   addr      out ADDR_W    instruction-memory write address
//   wEn       out 1         instruction-memory write enable
//   wDat      out DATA_W    instruction-memory write data
//   working   out 1         processor run enable
//   count     out ADDR_W+1  words written in the current or last load
//   error     out 1         load failed (sticky until the next start)
module imem_loader
  import proc_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 512
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              halt,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic [ADDR_W-1:0] addr,
  output logic              wEn,
  output logic [DATA_W-1:0] wDat,
  output logic              working,
  output logic [ADDR_W:0]   count,
  output logic              error
);

  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(DEPTH - 1);

  ldr_state_e state, nxt;

  logic acc;     // handshake completes this cycle
  logic op_ok;   // accepted word may be written
  logic wr;      // word is written this cycle
  logic at_end;  // accepted word lands on the last writable address
  logic clr;     // start honoured this cycle

`ifdef IMEM_LOADER_OPCODE_CHECK_EN
  opcode_check u_opc (
    .opcode (in_data[OPC_HI:OPC_LO]),
    .legal  (op_ok)
  );
`else
  assign op_ok = 1'b1;
`endif

  // in_ready is a registered decode of LOAD, so the handshake alone implies
  // we are in LOAD.
  assign acc    = in_valid & in_ready;
  assign wr     = acc & op_ok;
  assign at_end = (count == LAST_IDX);
  assign clr    = start & ((state == ST_IDLE) | (state == ST_ERROR));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE:  if (start) nxt = ST_LOAD;
      ST_LOAD: begin
        if (acc) begin
          if (!op_ok)      nxt = ST_ERROR;
          else if (in_last) nxt = ST_RUN;   // exact fit at DEPTH-1 is legal
          else if (at_end)  nxt = ST_ERROR; // overflow; this word still written
        end
      end
      ST_RUN:   if (halt)  nxt = ST_IDLE;
      ST_ERROR: if (start) nxt = ST_LOAD;
      default:  nxt = ST_IDLE;
    endcase
  end

  // Registered outputs. count doubles as the address counter: it always
  // holds the address of the next word to be written.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      addr     <= '0;
      wEn      <= 1'b0;
      wDat     <= '0;
      count    <= '0;
      in_ready <= 1'b0;
      working  <= 1'b0;
      error    <= 1'b0;
    end else begin
      wEn      <= wr;
      if (wr) begin
        addr <= count[ADDR_W-1:0];
        wDat <= in_data;
      end
      if (clr)     count <= '0;
      else if (wr) count <= count + (ADDR_W+1)'(1);
      in_ready <= (nxt == ST_LOAD);
      // Requiring state==RUN delays working by one cycle past the edge that
      // entered RUN, so it never overlaps the final wEn cycle.
      working  <= (state == ST_RUN) & (nxt == ST_RUN);
      error    <= (nxt == ST_ERROR);
    end
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Program loader that sits directly upstream of the processor's instruction-memory write port. Accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them to consecutive instruction-memory addresses from 0 while holding the processor idle. After the final word is written, it raises `working` to start execution. It replaces hand-driven `addr`/`wEn`/`wDat`/`working` sequencing.

## Interface
Parameters:
- `ADDR_W`, 9: instruction-memory address width.
- `DATA_W`, 32: instruction word width.
- `DEPTH`, 512: number of writable words; must be ≤ 2**ADDR_W.

Ports:
- Clock and reset: one clock, `clock`. Reset is asynchronous and active-low, `reset_n`.
- `clock`  in  1  system clock, 50 MHz nominal.
- `reset_n`  in  1  asynchronous active-low reset.
- `start`  in  1  begin a load; honoured in IDLE and ERROR only.
- `halt`  in  1  stop execution; honoured in RUN only.
- `in_valid`  in  1  `in_data` holds a word.
- `in_data`  in  DATA_W  instruction word.
- `in_last`  in  1  final word of the program; qualified by `in_valid`.
- `in_ready`  out  1  loader accepts a word this cycle.
- `addr`  out  ADDR_W  instruction-memory write address.
- `wEn`  out  1  instruction-memory write enable.
- `wDat`  out  DATA_W  instruction-memory write data.
- `working`  out  1  processor run enable.
- `count`  out  ADDR_W+1  words written in the current or last load.
- `error`  out  1  load failed; sticky.

## Operation
- States: IDLE, LOAD, RUN, ERROR.
- IDLE: `start` moves to LOAD and clears the address counter and `count` to 0.
- LOAD: `in_ready`=1. A word is accepted on the edge where `in_valid & in_ready`. On acceptance, `addr`←counter, `wDat`←`in_data`, `wEn`←1, counter and `count` increment.
  - Accepted word with `in_last`=1: go to RUN.
  - Accepted word at address DEPTH-1 with `in_last`=0: go to ERROR (overflow). That word is still written.
  - Cycle with no accepted word: `wEn`←0.
- RUN: `working`=1, `wEn`=0, `in_ready`=0. `halt` returns to IDLE and drops `working`. `count` holds its value.
- ERROR: `error`=1, `working`=0, `in_ready`=0. `start` moves to LOAD and clears `error`.
- `in_last` at address DEPTH-1 is a legal exact fit and goes to RUN, not ERROR.
- `start` in LOAD or RUN is ignored. `halt` outside RUN is ignored.
- Minimum program length is one word. There is no empty load.

## Timing
- All outputs are registered.
- Reset values: state IDLE, `addr`=0, `wEn`=0, `wDat`=0, `working`=0, `count`=0, `error`=0, `in_ready`=0.
- `in_ready` is a state decode and is high the cycle after the `start` edge.
- Write latency is 1 cycle: a word accepted at edge k is presented as `addr`/`wDat`/`wEn`=1 during cycle k→k+1. The memory captures it at edge k+1.
- `working` rises at the edge after the last `wEn` cycle. There is never a cycle with `wEn` and `working` both high.
- Back-to-back: with `in_valid` held high, one word is written per clock.
- Reset mid-load asserts asynchronously. Outputs clear immediately. Instruction-memory contents are untouched.

## Configuration
- `IMEM_LOADER_OPCODE_CHECK_EN` defined:
  - Each accepted word's bits [31:24] are checked against the legal opcode set.
  - Any other opcode sends the block to ERROR. That word is not written (`wEn` stays 0) and `count` does not increment.
- Undefined: no checking; every word is written.

## Structure
- Shared package `proc_pkg` holds:
  - opcode constants: `OP_IRMOV`=8'h10, `OP_ADD`=8'h20, `OP_SUB`=8'h21, `OP_AND`=8'h32;
  - field positions: opcode [31:24], rA [23:20], rB [19:16], imm [15:0];
  - the loader state enum.
- One sub-module is natural: `opcode_check`, combinational legality decode, instantiated only under the macro.

## Test plan
- Reset, `start`, then stream the 9-word program 0x1000001c, 0x1001001e, 0x10020020, 0x10030022, 0x10040024, 0x10050026, 0x20100000, 0x21320000, 0x32450000 (last on the ninth word):
  - nine `wEn` pulses at `addr` 0..8 with matching `wDat`;
  - `count`=9;
  - `working`=1 one cycle after the final write.
- Gapped `in_valid` (valid every other cycle) → `wEn` only on accepted words, addresses contiguous 0..N-1, `in_ready` constant 1.
- DEPTH=4, stream 4 words with no `in_last`:
  - `error`=1 and `count`=4;
  - `working` stays 0;
  - a following `start` clears `error`.
- DEPTH=4, 4 words with `in_last` on the fourth → RUN, `error`=0.
- `halt` in RUN → `working`=0 next cycle, state IDLE. `start` in RUN is ignored.
- `reset_n` pulsed low after 3 words → all outputs 0 immediately. With `IMEM_LOADER_OPCODE_CHECK_EN`, word 0x55000000 → ERROR, no `wEn` for it.
